alu_multicycle: RTL and testbench

//  Parametrised, registered ALU for the multi-cycle CPU datapath, with valid/ready handshakes on input and output.
//  - Extends the op set with xor, nor, signed/unsigned set-less-than, shifts and an optional iterative multiply.
//  - Adds a registered Zero flag and a signed Overflow flag.
//  - Sits between the register-file read stage and the writeback mux; stalls upstream while busy.

---
 rtl/alu_multicycle.sv | 193 +++++++++++++++++++
 tb/tb_alu_multicycle.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// Registered multi-cycle ALU with valid/ready handshakes on both sides.
// Define ALU_MUL_EN to build the iterative shift-add multiply (op 1100) and drive busy.
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUOp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             Zero,
  output logic             Overflow,
  output logic             busy
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_RSUB = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_NOR  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'b1100;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             accept;

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_next;
`endif

  // Single-cycle datapath: result and signed-overflow flag for the presented op.
  logic [WIDTH-1:0] sum_ab, dif_ab, dif_ba;
  logic [WIDTH-1:0] op_res;
  logic             op_ovf;

  always_comb begin
    sum_ab = A + B;
    dif_ab = A - B;
    dif_ba = B - A;
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    op_res = '0;
    op_ovf = 1'b0;
    case (ALUOp)
      OP_ADD: begin
        op_res = sum_ab;
        op_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum_ab[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        op_res = dif_ab;
        op_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (dif_ab[WIDTH-1] != A[WIDTH-1]);
      end
      OP_RSUB: begin
        op_res = dif_ba;
        op_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (dif_ba[WIDTH-1] != B[WIDTH-1]);
      end
      OP_OR:   op_res = A | B;
      OP_AND:  op_res = A & B;
      OP_XOR:  op_res = A ^ B;
      OP_NOR:  op_res = ~(A | B);
      OP_SLT:  op_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: op_res = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_SLL:  op_res = B << A[SHW-1:0];
      OP_SRL:  op_res = B >> A[SHW-1:0];
      OP_SRA:  op_res = $unsigned($signed(B) >>> A[SHW-1:0]);
      default: begin
        op_res = '0;
        op_ovf = 1'b0;
      end
    endcase
  end

  assign in_ready  = !rst && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign Zero      = zero_q;
  assign Overflow  = ovf_q;

`ifdef ALU_MUL_EN
  assign busy     = (state_q == ST_CALC);
  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
`else
  assign busy = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
`ifdef ALU_MUL_EN
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if ((state_q == ST_DONE) && out_ready) state_d = ST_IDLE;
        if (accept) begin
`ifdef ALU_MUL_EN
          if (ALUOp == OP_MUL) begin
            state_d  = ST_CALC;
            acc_d    = '0;
            mcand_d  = A;
            mplier_d = B;
            cnt_d    = '0;
          end else
`endif
          begin
            state_d  = ST_DONE;
            result_d = op_res;
            zero_d   = (op_res == '0);
            ovf_d    = op_ovf;
          end
        end
      end
      ST_CALC: begin
`ifdef ALU_MUL_EN
        // One multiplier bit per cycle; the last step writes the product directly.
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == SHW'(WIDTH - 1)) begin
          state_d  = ST_DONE;
          result_d = acc_next;
          zero_d   = (acc_next == '0);
          ovf_d    = 1'b0;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef ALU_MUL_EN
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
`ifdef ALU_MUL_EN
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle (default build or with ALU_MUL_EN).
module tb_alu_multicycle;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_s;
  logic [W-1:0] b_s;
  logic [3:0]   op_s;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         ovf;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;

  alu_multicycle #(.WIDTH(W), .SHW(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a_s),
    .B         (b_s),
    .ALUOp     (op_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .Zero      (zero),
    .Overflow  (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one single-cycle op from IDLE with out_ready=1 and check the 1-cycle result.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] r, input logic z,
                        input logic o);
    check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    op_s = op; a_s = a; b_s = b; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check({tag, ".out_valid"}, 64'(out_valid), 64'd1);
    check({tag, ".result"}, 64'(result), 64'(r));
    check({tag, ".zero"}, 64'(zero), 64'(z));
    check({tag, ".ovf"}, 64'(ovf), 64'(o));
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int busy_cnt;
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    a_s = '0; b_s = '0; op_s = 4'h0;
    repeat (2) step();

    // Reset state
    check("rst.in_ready", 64'(in_ready), 64'd0);
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.result", 64'(result), 64'd0);
    check("rst.zero", 64'(zero), 64'd0);
    check("rst.ovf", 64'(ovf), 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    in_valid = 1'b0;
    rst = 1'b0;
    step();

    // Single-cycle ops
    run_op("add_ovf",  4'h0, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0, 1'b1);
    run_op("add_wrap", 4'h0, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1'b0);
    run_op("sub_zero", 4'h1, 32'd5,         32'd5,         32'h0,         1'b1, 1'b0);
    run_op("sub_ovf",  4'h1, 32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 1'b0, 1'b1);
    run_op("rsub",     4'h2, 32'd3,         32'd1,         32'hFFFF_FFFE, 1'b0, 1'b0);
    run_op("rsub_ovf", 4'h2, 32'h1,         32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1);
    run_op("or",       4'h3, 32'h0000_F0F0, 32'h0000_0F00, 32'h0000_FFF0, 1'b0, 1'b0);
    run_op("and",      4'h4, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1'b0, 1'b0);
    run_op("xor",      4'h5, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0, 1'b0);
    run_op("nor",      4'h6, 32'h0,         32'h0,         32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("slt_neg",  4'h7, 32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0, 1'b0);
    run_op("slt_pos",  4'h7, 32'h1,         32'hFFFF_FFFF, 32'h0,         1'b1, 1'b0);
    run_op("sltu_big", 4'h8, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1'b0);
    run_op("sltu_sml", 4'h8, 32'h1,         32'hFFFF_FFFF, 32'h1,         1'b0, 1'b0);
    run_op("sll_mask", 4'h9, 32'h24,        32'h1,         32'h10,        1'b0, 1'b0);
    run_op("srl",      4'hA, 32'd31,        32'h8000_0000, 32'h1,         1'b0, 1'b0);
    run_op("sra",      4'hB, 32'd4,         32'h8000_0000, 32'hF800_0000, 1'b0, 1'b0);
    run_op("undef",    4'hD, 32'h1234,      32'h5678,      32'h0,         1'b1, 1'b0);

    // Back-to-back: three ops on consecutive edges with out_ready=1
    op_s = 4'h0; a_s = 32'd10; b_s = 32'd20; in_valid = 1'b1;
    step();
    check("b2b1.result", 64'(result), 64'd30);
    check("b2b1.in_ready", 64'(in_ready), 64'd1);
    op_s = 4'h1; a_s = 32'd100; b_s = 32'd1;
    step();
    check("b2b2.out_valid", 64'(out_valid), 64'd1);
    check("b2b2.result", 64'(result), 64'd99);
    check("b2b2.in_ready", 64'(in_ready), 64'd1);
    op_s = 4'h5; a_s = 32'hF0; b_s = 32'hFF;
    step();
    in_valid = 1'b0;
    check("b2b3.out_valid", 64'(out_valid), 64'd1);
    check("b2b3.result", 64'(result), 64'h0F);
    step();
    check("b2b.idle", 64'(out_valid), 64'd0);

    // Output stall: result held, new op not taken until out_ready returns
    out_ready = 1'b0;
    op_s = 4'h0; a_s = 32'd2; b_s = 32'd3; in_valid = 1'b1;
    step();
    op_s = 4'h1; a_s = 32'd10; b_s = 32'd4;
    for (int i = 0; i < 4; i++) begin
      check("hold.out_valid", 64'(out_valid), 64'd1);
      check("hold.result", 64'(result), 64'd5);
      check("hold.in_ready", 64'(in_ready), 64'd0);
      step();
    end
    check("hold.last", 64'(result), 64'd5);
    out_ready = 1'b1;
    #1;
    check("release.in_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    check("release.result", 64'(result), 64'd6);
    check("release.out_valid", 64'(out_valid), 64'd1);
    step();

    // Reset while an un-consumed result sits in DONE
    out_ready = 1'b0;
    run_op_nodrain();
    rst = 1'b1;
    #1;
    check("rst_done.out_valid", 64'(out_valid), 64'd0);
    check("rst_done.result", 64'(result), 64'd0);
    check("rst_done.ovf", 64'(ovf), 64'd0);
    check("rst_done.in_ready", 64'(in_ready), 64'd0);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    run_op("post_rst", 4'h0, 32'd7, 32'd8, 32'd15, 1'b0, 1'b0);

`ifdef ALU_MUL_EN
    // Iterative multiply: busy WIDTH cycles, out_valid WIDTH+1 cycles after accept
    op_s = 4'hC; a_s = 32'd1234; b_s = 32'd5678; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("mul.in_ready_busy", 64'(in_ready), 64'd0);
    lat = 1;
    busy_cnt = 0;
    while (!out_valid && lat < 100) begin
      if (busy) busy_cnt++;
      step();
      lat++;
    end
    check("mul.latency", 64'(lat), 64'd33);
    check("mul.busy_cycles", 64'(busy_cnt), 64'd32);
    check("mul.result", 64'(result), 64'd7006652);
    check("mul.zero", 64'(zero), 64'd0);
    check("mul.busy_done", 64'(busy), 64'd0);
    step();

    // Reset in the middle of a second multiply
    op_s = 4'hC; a_s = 32'd99; b_s = 32'd77; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    check("mul2.busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("mul_rst.busy", 64'(busy), 64'd0);
    check("mul_rst.out_valid", 64'(out_valid), 64'd0);
    check("mul_rst.result", 64'(result), 64'd0);
    check("mul_rst.zero", 64'(zero), 64'd0);
    step();
    rst = 1'b0;
    step();
    run_op("post_mul_rst", 4'h3, 32'h1, 32'h2, 32'h3, 1'b0, 1'b0);
`else
    busy_cnt = 0;
    lat = 0;
    // Without the multiplier, 1100 behaves like any undefined code
    run_op("mul_off", 4'hC, 32'd1234, 32'd5678, 32'h0, 1'b1, 1'b0);
    check("mul_off.busy", 64'(busy), 64'd0);
    check("mul_off.counts", 64'(busy_cnt + lat), 64'(busy));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Accept an ADD with out_ready low and leave the result parked in DONE.
  task automatic run_op_nodrain();
    op_s = 4'h0; a_s = 32'd40; b_s = 32'd2; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("park.result", 64'(result), 64'd42);
    check("park.out_valid", 64'(out_valid), 64'd1);
  endtask

endmodule
